// File: rtl/dm_port_arbiter_pkg.sv
// rtl/dm_port_arbiter_pkg.sv - shared encodings for the data-memory port arbiter
// State, grant and ByteWidth codes are shared with dm and ex_mem_decoder.
package dm_port_arbiter_pkg;

    localparam int STARVE_LIMIT_DEF = 4;
    localparam int MAX_BURST_DEF    = 4;

    localparam logic [3:0] STARVE_CNT_MAX = 4'hF;

    typedef enum logic [1:0] {
        S_PIPE  = 2'd0,
        S_FORCE = 2'd1,
        S_LOCK  = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_PIPE = 2'd1,
        GNT_DMA  = 2'd2
    } arb_gnt_e;

    localparam logic [1:0] BW_BYTE = 2'd0;
    localparam logic [1:0] BW_HALF = 2'd1;
    localparam logic [1:0] BW_WORD = 2'd2;

endpackage

// File: rtl/arb_starve_cnt.sv
// rtl/arb_starve_cnt.sv - saturating DMA starvation counter with limit compare
// at_limit_o flags the last denied cycle before a forced DMA grant.
module arb_starve_cnt
    import dm_port_arbiter_pkg::*;
#(
    parameter int LIMIT = STARVE_LIMIT_DEF
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic inc_i,
    input  logic clr_i,
    output logic at_limit_o
);

    logic [3:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = 4'd0;
        end else if (inc_i && (cnt_q != STARVE_CNT_MAX)) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_limit_o = (cnt_q == 4'(LIMIT - 1));

endmodule

// File: rtl/dm_port_arbiter.sv
// rtl/dm_port_arbiter.sv - shares the dm port between the MEM stage and a DMA/debug master
// Optional DMA burst locking is enabled by defining DM_ARB_BURST_EN.
module dm_port_arbiter
    import dm_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
    parameter int MAX_BURST    = MAX_BURST_DEF
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        p_req_i,
    input  logic        p_we_i,
    input  logic [31:0] p_addr_i,
    input  logic [31:0] p_wdata_i,
    input  logic [1:0]  p_bw_i,
    input  logic        p_sext_i,
    output logic [31:0] p_rdata_o,
    output logic        p_stall_o,
    input  logic        d_valid_i,
    output logic        d_ready_o,
    input  logic        d_we_i,
    input  logic [31:0] d_addr_i,
    input  logic [31:0] d_wdata_i,
    input  logic [1:0]  d_bw_i,
    input  logic        d_lock_i,
    output logic        d_rvalid_o,
    output logic [31:0] d_rdata_o,
    output logic        d_err_o,
    output logic [31:0] dm_addr_o,
    output logic        dm_we_o,
    output logic [31:0] dm_wdata_o,
    output logic [1:0]  dm_bw_o,
    output logic        dm_sext_o,
    input  logic [31:0] dm_rdata_i,
    input  logic        dm_err_i
);

    arb_state_e  state_q, state_d;
    arb_gnt_e    gnt;
    logic        d_hs;
    logic        d_deny;
    logic        at_limit;
    logic        d_rvalid_q;
    logic [31:0] d_rdata_q;
    logic        d_err_q;

`ifdef DM_ARB_BURST_EN
    logic [3:0]  beat_cnt_q, beat_cnt_d;
    logic        lock_req;
`else
    logic        unused_cfg;
    assign unused_cfg = d_lock_i | (MAX_BURST > 0);
`endif

    always_comb begin
        gnt = GNT_NONE;
        case (state_q)
            S_PIPE: begin
                if (p_req_i) begin
                    gnt = GNT_PIPE;
                end else if (d_valid_i) begin
                    gnt = GNT_DMA;
                end
            end
            default: gnt = GNT_DMA;
        endcase
    end

    assign d_ready_o = (gnt == GNT_DMA) & d_valid_i;
    assign d_hs      = d_valid_i & d_ready_o;
    assign d_deny    = d_valid_i & ~d_ready_o;
    assign p_stall_o = p_req_i & (gnt == GNT_DMA);
    assign p_rdata_o = dm_rdata_i;

    // With no grant the pipe fields still drive dm, only the write enable is masked.
    always_comb begin
        dm_addr_o  = p_addr_i;
        dm_wdata_o = p_wdata_i;
        dm_bw_o    = p_bw_i;
        dm_sext_o  = p_sext_i;
        dm_we_o    = 1'b0;
        case (gnt)
            GNT_PIPE: dm_we_o = p_we_i;
            GNT_DMA: begin
                dm_addr_o  = d_addr_i;
                dm_wdata_o = d_wdata_i;
                dm_bw_o    = d_bw_i;
                dm_sext_o  = 1'b0;
                dm_we_o    = d_we_i;
            end
            default: dm_we_o = 1'b0;
        endcase
    end

    arb_starve_cnt #(
        .LIMIT(STARVE_LIMIT)
    ) u_starve_cnt (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .inc_i     (d_deny),
        .clr_i     (~d_deny),
        .at_limit_o(at_limit)
    );

`ifdef DM_ARB_BURST_EN
    // A single-beat burst limit never needs the locked state.
    assign lock_req = d_hs & d_lock_i & (MAX_BURST > 1);
`endif

    always_comb begin
        state_d = state_q;
`ifdef DM_ARB_BURST_EN
        beat_cnt_d = beat_cnt_q;
`endif
        case (state_q)
            S_PIPE: begin
                if (d_deny && at_limit) begin
                    state_d = S_FORCE;
                end
`ifdef DM_ARB_BURST_EN
                else if (lock_req) begin
                    state_d    = S_LOCK;
                    beat_cnt_d = 4'd1;
                end
`endif
            end
            S_FORCE: begin
                state_d = S_PIPE;
`ifdef DM_ARB_BURST_EN
                if (lock_req) begin
                    state_d    = S_LOCK;
                    beat_cnt_d = 4'd1;
                end
`endif
            end
            S_LOCK: begin
`ifdef DM_ARB_BURST_EN
                if (d_hs) begin
                    if (!d_lock_i || (beat_cnt_q == 4'(MAX_BURST - 1))) begin
                        state_d    = S_PIPE;
                        beat_cnt_d = 4'd0;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 4'd1;
                    end
                end
`else
                state_d = S_PIPE;
`endif
            end
            default: state_d = S_PIPE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_PIPE;
            d_rvalid_q <= 1'b0;
            d_rdata_q  <= 32'd0;
            d_err_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            d_rvalid_q <= d_hs & ~d_we_i;
            if (d_hs) begin
                d_err_q <= dm_err_i;
                if (!d_we_i) begin
                    d_rdata_q <= dm_rdata_i;
                end
            end
        end
    end

`ifdef DM_ARB_BURST_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            beat_cnt_q <= 4'd0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
        end
    end
`endif

    assign d_rvalid_o = d_rvalid_q;
    assign d_rdata_o  = d_rdata_q;
    assign d_err_o    = d_err_q;

endmodule
